// File: rtl/wb_cpu_arbiter_if.sv
// Wishbone bundle between the CPU's instruction/data masters, the arbiter and the
// system interconnect. The arbiter uses the slave view, the surrounding logic the master view.
interface wb_cpu_arbiter_if;
    logic        icmu_cyc_i, icmu_stb_i, icmu_we_i;
    logic [31:2] icmu_addr_i;
    logic [2:0]  icmu_cti_i;
    logic [1:0]  icmu_bte_i;
    logic [3:0]  icmu_sel_i;
    logic [31:0] icmu_data_i;
    logic [31:0] icmu_data_o;
    logic        icmu_ack_o;

    logic        dcmu_cyc_i, dcmu_stb_i, dcmu_we_i;
    logic [31:2] dcmu_addr_i;
    logic [2:0]  dcmu_cti_i;
    logic [1:0]  dcmu_bte_i;
    logic [3:0]  dcmu_sel_i;
    logic [31:0] dcmu_data_i;
    logic [31:0] dcmu_data_o;
    logic        dcmu_ack_o;

    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:2] wbm_addr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_data_o;
    logic [31:0] wbm_data_i;
    logic        wbm_ack_i;

    modport slave (
        input  icmu_cyc_i, icmu_stb_i, icmu_we_i, icmu_addr_i, icmu_cti_i, icmu_bte_i,
               icmu_sel_i, icmu_data_i,
        output icmu_data_o, icmu_ack_o,
        input  dcmu_cyc_i, dcmu_stb_i, dcmu_we_i, dcmu_addr_i, dcmu_cti_i, dcmu_bte_i,
               dcmu_sel_i, dcmu_data_i,
        output dcmu_data_o, dcmu_ack_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_cti_o, wbm_bte_o,
               wbm_sel_o, wbm_data_o,
        input  wbm_data_i, wbm_ack_i
    );

    modport master (
        output icmu_cyc_i, icmu_stb_i, icmu_we_i, icmu_addr_i, icmu_cti_i, icmu_bte_i,
               icmu_sel_i, icmu_data_i,
        input  icmu_data_o, icmu_ack_o,
        output dcmu_cyc_i, dcmu_stb_i, dcmu_we_i, dcmu_addr_i, dcmu_cti_i, dcmu_bte_i,
               dcmu_sel_i, dcmu_data_i,
        input  dcmu_data_o, dcmu_ack_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_cti_o, wbm_bte_o,
               wbm_sel_o, wbm_data_o,
        output wbm_data_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_cpu_arbiter.sv
// Round-robin arbiter merging the CPU's ICMU and DCMU Wishbone masters onto one bus,
// granting whole cyc-held bus cycles, with a watchdog that fakes an ack for silent slaves.

// Return path for one master: ack only to the owner, read data broadcast while granted.
module wb_cpu_arbiter_port (
    input  logic        own,
    input  logic        active,
    input  logic        force_term,
    input  logic        wbm_ack,
    input  logic [31:0] wbm_data,
    output logic        ack,
    output logic [31:0] data
);
    // In a forced-termination cycle the slave's late ack is swallowed.
    assign ack  = own & (force_term | wbm_ack);
    assign data = (active && !(own && force_term)) ? wbm_data : 32'h0;
endmodule

module wb_cpu_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    wb_cpu_arbiter_if.slave bus,
    output logic            grant_icmu,
    output logic            grant_dcmu,
    output logic            bus_timeout
);
    localparam int NUM_M = 2;
    localparam int CW    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:2] addr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic [31:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    wb_req_t [NUM_M-1:0]        req;      // 0 = ICMU, 1 = DCMU
    wb_req_t                    sel_req;
    state_t                     state, state_nxt;
    logic                       last_d;   // DCMU was the most recent grant
    logic [NUM_M-1:0]           own;
    logic                       busy;
    logic                       wbm_stb;
    logic                       force_q, force_nxt;
    logic [CW-1:0]              wd_cnt, wd_cnt_nxt;
    logic [NUM_M-1:0]           ack_o;
    logic [NUM_M-1:0][31:0]     data_o;

    assign req[0] = {bus.icmu_cyc_i, bus.icmu_stb_i, bus.icmu_we_i, bus.icmu_addr_i,
                     bus.icmu_cti_i, bus.icmu_bte_i, bus.icmu_sel_i, bus.icmu_data_i};
    assign req[1] = {bus.dcmu_cyc_i, bus.dcmu_stb_i, bus.dcmu_we_i, bus.dcmu_addr_i,
                     bus.dcmu_cti_i, bus.dcmu_bte_i, bus.dcmu_sel_i, bus.dcmu_data_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt != IDLE)
                last_d <= (state_nxt == GNT_D);
        end
    end

    // A grant is held for as long as the owner keeps cyc up, bursts included.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req[0].cyc && req[1].cyc) state_nxt = last_d ? GNT_I : GNT_D;
                else if (req[0].cyc)          state_nxt = GNT_I;
                else if (req[1].cyc)          state_nxt = GNT_D;
            end
            GNT_I: if (!req[0].cyc) state_nxt = req[1].cyc ? GNT_D : IDLE;
            GNT_D: if (!req[1].cyc) state_nxt = req[0].cyc ? GNT_I : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign own     = {state == GNT_D, state == GNT_I};
    assign busy    = (state != IDLE);
    assign sel_req = own[1] ? req[1] : (own[0] ? req[0] : '0);
    assign wbm_stb = sel_req.stb & ~force_q;

    assign bus.wbm_cyc_o  = sel_req.cyc;
    assign bus.wbm_stb_o  = wbm_stb;
    assign bus.wbm_we_o   = sel_req.we;
    assign bus.wbm_addr_o = sel_req.addr;
    assign bus.wbm_cti_o  = sel_req.cti;
    assign bus.wbm_bte_o  = sel_req.bte;
    assign bus.wbm_sel_o  = sel_req.sel;
    assign bus.wbm_data_o = sel_req.data;

    // Watchdog: a stall that survives to the limit schedules one forced-termination cycle.
    always_comb begin
        wd_cnt_nxt = '0;
        force_nxt  = 1'b0;
        if (TIMEOUT != 0 && wbm_stb && !bus.wbm_ack_i && state_nxt == state) begin
            if (wd_cnt == LIMIT) force_nxt  = 1'b1;
            else                 wd_cnt_nxt = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            force_q <= 1'b0;
        end else begin
            wd_cnt  <= wd_cnt_nxt;
            force_q <= force_nxt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_M; g++) begin : g_port
            wb_cpu_arbiter_port u_port (
                .own        (own[g]),
                .active     (busy),
                .force_term (force_q),
                .wbm_ack    (bus.wbm_ack_i),
                .wbm_data   (bus.wbm_data_i),
                .ack        (ack_o[g]),
                .data       (data_o[g])
            );
        end
    endgenerate

    assign bus.icmu_ack_o  = ack_o[0];
    assign bus.icmu_data_o = data_o[0];
    assign bus.dcmu_ack_o  = ack_o[1];
    assign bus.dcmu_data_o = data_o[1];

    assign grant_icmu  = own[0];
    assign grant_dcmu  = own[1];
    assign bus_timeout = force_q;
endmodule
